// File: rtl/array_lane_packer.sv
// Packs a stream of ELEM_W-bit elements into NUM_ELEM-lane words, lane 0 first; in_last closes a partial word.
// Latency: out_valid rises one cycle after the accept that closes a word; one element per cycle sustained.
// Backpressure: a held word is never overwritten; in_ready = FILL | out_ready, so a stalled word blocks input.
module array_lane_packer #(
    parameter int ELEM_W   = 4,
    parameter int NUM_ELEM = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ELEM_W-1:0]            in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_ELEM*ELEM_W-1:0]   out_data,
    output logic [NUM_ELEM-1:0]          out_keep,
    output logic [$clog2(NUM_ELEM+1)-1:0] out_count
);

    localparam int IDX_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
    localparam int CNT_W = $clog2(NUM_ELEM + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             in_fire;
    logic             out_fire;

    // Input may be taken while collecting, or while the held word leaves this same cycle.
    assign in_ready = (state == FILL) | out_ready;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Lane accumulation and FILL/HOLD sequencing; outputs are the accumulating word itself.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FILL;
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_count <= '0;
        end else if (state == FILL) begin
            if (in_fire) begin
                for (int k = 0; k < NUM_ELEM; k++) begin
                    if (idx == IDX_W'(k)) begin
                        out_data[k*ELEM_W +: ELEM_W] <= in_data;
                        out_keep[k]                  <= 1'b1;
                    end
                end
                out_count <= out_count + CNT_W'(1);
                if ((idx == LAST_IDX) || in_last) begin
                    state     <= HOLD;
                    out_valid <= 1'b1;
                    idx       <= '0;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end else begin
            if (out_fire) begin
                if (in_fire) begin
                    // Old word leaves while the new element opens a fresh word in lane 0.
                    out_data  <= (NUM_ELEM*ELEM_W)'(in_data);
                    out_keep  <= NUM_ELEM'(1);
                    out_count <= CNT_W'(1);
                    if ((NUM_ELEM == 1) || in_last) begin
                        idx <= '0;
                    end else begin
                        state     <= FILL;
                        out_valid <= 1'b0;
                        idx       <= IDX_W'(1);
                    end
                end else begin
                    state     <= FILL;
                    out_valid <= 1'b0;
                    idx       <= '0;
                    out_data  <= '0;
                    out_keep  <= '0;
                    out_count <= '0;
                end
            end
        end
    end

endmodule
